// File: rtl/mc_multi_ch_ctrl.sv
// Multi-channel memory controller: round-robin arbitration of NUM_CH request
// channels onto one shared byte-enabled word array, fixed-latency responses.
module mc_multi_ch_ctrl #(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DEPTH      = 200,
   parameter int unsigned RD_LAT     = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_CH-1:0]              en,
   input  logic [NUM_CH-1:0]              w_r,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]   wr_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
   input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] byte_en,
   output logic [NUM_CH-1:0]              ready,
   output logic [NUM_CH-1:0]              resp_valid,
   output logic [NUM_CH*DATA_WIDTH-1:0]   data_out,
   output logic [NUM_CH-1:0]              slv_error
);

   localparam int unsigned NB     = DATA_WIDTH / 8;
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DATA_WIDTH % 8 != 0 || NUM_CH < 1 || NUM_CH > 8 || DEPTH < 1 ||
       DEPTH > 2**ADDR_WIDTH || RD_LAT < 1) begin : g_param_check
      $error("mc_multi_ch_ctrl: illegal parameter combination");
   end

   typedef struct packed {
      logic                  v;
      logic [CH_W-1:0]       ch;
      logic [DATA_WIDTH-1:0] d;
      logic                  e;
   } rsp_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [CH_W-1:0]       ptr;
   logic [CH_W-1:0]       ptr_nxt;
   logic [CH_W-1:0]       grant;
   logic                  found;
   logic                  accept;

   logic                  sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [NB-1:0]         sel_be;
   logic [MEM_AW-1:0]     mem_idx;
   logic                  in_range;
   logic [DATA_WIDTH-1:0] rd_data;

   rsp_t                  acc_rsp;
   rsp_t                  pipe [RD_LAT];
   rsp_t                  last;
   logic [DATA_WIDTH-1:0] hold [NUM_CH];

   // Rotating priority: visit channels ptr, ptr+1, ... and take the first requester.
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         for (int unsigned j = 0; j < NUM_CH; j++) begin
            if (!found && en[j] && (j == (32'(ptr) + i) % NUM_CH)) begin
               found = 1'b1;
               grant = CH_W'(j);
            end
         end
      end
   end

   always_comb begin
      accept  = found && !reset;
      ptr_nxt = CH_W'((32'(grant) + 1) % NUM_CH);
      ready   = '0;
      for (int unsigned j = 0; j < NUM_CH; j++) begin
         ready[j] = accept && (32'(grant) == j);
      end
   end

   always_comb begin
      sel_wr   = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      sel_be   = '0;
      for (int unsigned j = 0; j < NUM_CH; j++) begin
         if (32'(grant) == j) begin
            sel_wr   = w_r[j];
            sel_addr = wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = in_data[j*DATA_WIDTH +: DATA_WIDTH];
            sel_be   = byte_en[j*NB +: NB];
         end
      end
   end

   always_comb begin
      in_range = (32'(sel_addr) < DEPTH);
      mem_idx  = MEM_AW'(sel_addr);
      rd_data  = '0;
      if (in_range) begin
         rd_data = mem[mem_idx];
      end
      acc_rsp.v  = accept;
      acc_rsp.ch = grant;
      acc_rsp.d  = sel_wr ? '0 : rd_data;
      acc_rsp.e  = !in_range;
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (accept && sel_wr && in_range) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (sel_be[b]) begin
               mem[mem_idx][b*8 +: 8] <= sel_data[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
         for (int unsigned k = 0; k < RD_LAT; k++) begin
            pipe[k] <= '0;
         end
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            hold[c] <= '0;
         end
      end else begin
         if (accept) begin
            ptr <= ptr_nxt;
         end
         pipe[0] <= acc_rsp;
         for (int unsigned k = 1; k < RD_LAT; k++) begin
            pipe[k] <= pipe[k-1];
         end
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (last.v && (32'(last.ch) == c)) begin
               hold[c] <= last.d;
            end
         end
      end
   end

   // The final pipeline stage drives the outputs directly; hold keeps data_out between strobes.
   always_comb begin
      last       = pipe[RD_LAT-1];
      resp_valid = '0;
      slv_error  = '0;
      data_out   = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         resp_valid[c] = last.v && (32'(last.ch) == c);
         slv_error[c]  = last.v && (32'(last.ch) == c) && last.e;
         data_out[c*DATA_WIDTH +: DATA_WIDTH] = (last.v && (32'(last.ch) == c)) ? last.d : hold[c];
      end
   end

endmodule

// File: tb/tb_mc_multi_ch_ctrl.sv
// Self-checking bench for mc_multi_ch_ctrl: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_mc_multi_ch_ctrl;

   localparam int NUM_CH = 2;
   localparam int DW     = 32;
   localparam int AW     = 8;
   localparam int DEPTH  = 200;
   localparam int RD_LAT = 2;
   localparam int NB     = DW / 8;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NUM_CH-1:0]      en;
   logic [NUM_CH-1:0]      w_r;
   logic [NUM_CH*AW-1:0]   wr_addr;
   logic [NUM_CH*DW-1:0]   in_data;
   logic [NUM_CH*NB-1:0]   byte_en;
   logic [NUM_CH-1:0]      ready;
   logic [NUM_CH-1:0]      resp_valid;
   logic [NUM_CH*DW-1:0]   data_out;
   logic [NUM_CH-1:0]      slv_error;

   mc_multi_ch_ctrl #(
      .NUM_CH     (NUM_CH),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .RD_LAT     (RD_LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .w_r        (w_r),
      .wr_addr    (wr_addr),
      .in_data    (in_data),
      .byte_en    (byte_en),
      .ready      (ready),
      .resp_valid (resp_valid),
      .data_out   (data_out),
      .slv_error  (slv_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      int          ch;
      logic [DW-1:0] d;
      bit          e;
      bit          known;
   } exp_t;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   bit            started  = 1'b0;
   int            last_grant = -1;
   int            mptr     = 0;
   logic [DW-1:0] mmem   [256];
   bit            mknown [256];
   exp_t          q [$];
   logic [DW-1:0] exp_do    [NUM_CH];
   bit            exp_known [NUM_CH];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model.
   task automatic tick();
      exp_t r;
      bit   cv;
      int   cch;
      bit   ce;
      int   g;
      int   a;
      bit   inr;
      @(negedge clk);
      cv = 1'b0; cch = 0; ce = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         r   = q.pop_front();
         cv  = 1'b1;
         cch = r.ch;
         ce  = r.e;
         exp_do[r.ch]    = r.d;
         exp_known[r.ch] = r.known;
      end
      g = -1;
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (g < 0 && en[(mptr + i) % NUM_CH]) g = (mptr + i) % NUM_CH;
         end
      end
      if (started) begin
         for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("ready[%0d]@%0d", c, cyc), 64'(ready[c]), 64'(g == c));
            check($sformatf("resp_valid[%0d]@%0d", c, cyc), 64'(resp_valid[c]), 64'(cv && cch == c));
            check($sformatf("slv_error[%0d]@%0d", c, cyc), 64'(slv_error[c]), 64'(cv && cch == c && ce));
            if (exp_known[c])
               check($sformatf("data_out[%0d]@%0d", c, cyc), 64'(data_out[c*DW +: DW]), 64'(exp_do[c]));
         end
      end
      last_grant = g;
      if (reset) begin
         q.delete();
         mptr = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            exp_do[c]    = '0;
            exp_known[c] = 1'b1;
         end
         started = 1'b1;
      end else if (g >= 0) begin
         a     = 32'(wr_addr[g*AW +: AW]);
         inr   = (a < DEPTH);
         r.due = cyc + RD_LAT;
         r.ch  = g;
         r.e   = !inr;
         if (w_r[g]) begin
            r.d     = '0;
            r.known = 1'b1;
            if (inr) begin
               for (int b = 0; b < NB; b++) begin
                  if (byte_en[g*NB + b]) mmem[a][b*8 +: 8] = in_data[g*DW + b*8 +: 8];
               end
               if (byte_en[g*NB +: NB] == '1) mknown[a] = 1'b1;
            end
         end else begin
            r.d     = inr ? mmem[a] : '0;
            r.known = inr ? mknown[a] : 1'b1;
         end
         q.push_back(r);
         mptr = (g + 1) % NUM_CH;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      en = '0;
      repeat (n) tick();
   endtask

   task automatic issue(input int c, input bit wr, input int addr, input logic [DW-1:0] d,
                        input logic [NB-1:0] be, output int acc);
      bit got;
      got = 1'b0;
      en[c]              = 1'b1;
      w_r[c]             = wr;
      wr_addr[c*AW +: AW] = AW'(addr);
      in_data[c*DW +: DW] = d;
      byte_en[c*NB +: NB] = be;
      acc = cyc;
      for (int k = 0; k < 16 && !got; k++) begin
         acc = cyc;
         tick();
         if (last_grant == c) got = 1'b1;
      end
      en[c] = 1'b0;
      check($sformatf("grant_ch%0d", c), 64'(got), 64'(1));
   endtask

   task automatic expect_resp(input int c, input int acc, input logic [DW-1:0] d, input bit e);
      if (cyc < acc + RD_LAT)
         check($sformatf("early_resp_ch%0d", c), 64'(resp_valid[c]), 64'(0));
      while (cyc < acc + RD_LAT) tick();
      check($sformatf("resp_strobe_ch%0d", c), 64'(resp_valid[c]), 64'(1));
      check($sformatf("resp_data_ch%0d", c), 64'(data_out[c*DW +: DW]), 64'(d));
      check($sformatf("resp_err_ch%0d", c), 64'(slv_error[c]), 64'(e));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      bit pend [NUM_CH];
      en = '0; w_r = '0; wr_addr = '0; in_data = '0; byte_en = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      repeat (5) begin
         tick();
         check("idle_ready", 64'(ready), 64'(0));
         check("idle_resp_valid", 64'(resp_valid), 64'(0));
         check("idle_slv_error", 64'(slv_error), 64'(0));
         check("idle_data_out", 64'(data_out), 64'(0));
      end

      issue(0, 1'b1, 5, 32'hDEADBEEF, 4'hF, acc);
      expect_resp(0, acc, 32'h0, 1'b0);
      idle(2);
      issue(0, 1'b0, 5, 32'h0, 4'h0, acc);
      expect_resp(0, acc, 32'hDEADBEEF, 1'b0);
      idle(2);

      issue(0, 1'b1, 5, 32'h11223344, 4'h5, acc);
      expect_resp(0, acc, 32'h0, 1'b0);
      idle(2);
      issue(0, 1'b0, 5, 32'h0, 4'h0, acc);
      expect_resp(0, acc, 32'hDE22BE44, 1'b0);
      idle(2);

      issue(1, 1'b1, 199, 32'hCAFEF00D, 4'hF, acc);
      expect_resp(1, acc, 32'h0, 1'b0);
      idle(2);
      issue(1, 1'b1, 200, 32'h12345678, 4'hF, acc);
      expect_resp(1, acc, 32'h0, 1'b1);
      idle(2);
      issue(1, 1'b0, 200, 32'h0, 4'h0, acc);
      expect_resp(1, acc, 32'h0, 1'b1);
      idle(2);
      issue(1, 1'b0, 199, 32'h0, 4'h0, acc);
      expect_resp(1, acc, 32'hCAFEF00D, 1'b0);
      idle(3);

      // Contention from a freshly reset pointer.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      w_r = '0;
      wr_addr = {8'd199, 8'd5};
      en = 2'b11;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) en = '0;
         #1;
         check($sformatf("contend_ready_k%0d", k), 64'(ready),
               64'((k < 4) ? ((k % 2) ? 2 : 1) : 0));
         check($sformatf("contend_resp_k%0d", k), 64'(resp_valid),
               64'((k >= 2) ? (((k - 2) % 2) ? 2 : 1) : 0));
         tick();
      end
      idle(3);

      // Reset one cycle after a read is accepted on ch0 (pointer then sits at 1).
      issue(0, 1'b0, 5, 32'h0, 4'h0, acc);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("flushed_resp_a", 64'(resp_valid), 64'(0));
      tick();
      check("flushed_resp_b", 64'(resp_valid), 64'(0));
      en = 2'b11;
      #1;
      check("ptr_after_reset", 64'(ready), 64'(2'b01));
      en = '0;
      #1;
      issue(1, 1'b0, 199, 32'h0, 4'h0, acc);
      expect_resp(1, acc, 32'hCAFEF00D, 1'b0);
      idle(2);
      issue(0, 1'b0, 5, 32'h0, 4'h0, acc);
      expect_resp(0, acc, 32'hDE22BE44, 1'b0);
      idle(3);

      for (int c = 0; c < NUM_CH; c++) pend[c] = 1'b0;
      repeat (400) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (!pend[c] && $urandom_range(2) == 0) begin
               int a;
               pend[c] = 1'b1;
               en[c]   = 1'b1;
               w_r[c]  = 1'($urandom_range(1));
               case ($urandom_range(3))
                  0:       a = $urandom_range(15, 0);
                  1:       a = $urandom_range(199, 190);
                  2:       a = $urandom_range(255, 200);
                  default: a = 5;
               endcase
               wr_addr[c*AW +: AW] = AW'(a);
               in_data[c*DW +: DW] = $urandom;
               byte_en[c*NB +: NB] = ($urandom_range(1) == 1) ? 4'hF : 4'($urandom_range(15));
            end
         end
         reset = ($urandom_range(63) == 0);
         tick();
         if (last_grant >= 0) begin
            pend[last_grant] = 1'b0;
            en[last_grant]   = 1'b0;
         end
      end
      reset = 1'b0;
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
